// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage between the EX/MEM and MEM/WB pipeline registers.
//   Performs loads and stores over a req/ack data-memory port. It aligns and extends
//   load data, selects the writeback source and registers the MEM/WB outputs.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid_i .. mem_write_i  instruction fields from the EX/MEM register
//   stall_o                    holds EX/MEM and earlier stages while an access is pending
//   dmem_*                     data-memory request port (word address, byte enables)
//   wb_valid_o/addr_o/data_o   registered register-file write, one-cycle pulse
//   misalign_o                 one-cycle pulse when a memory op is dropped as misaligned
// The byte-lane logic (4 byte enables, 4x/2x store replication) assumes XLEN == 32.
module mem_wb_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [XLEN-1:0]   advance_pc_i,
    input  logic [XLEN-1:0]   alu_result_i,
    input  logic [XLEN-1:0]   reg_2_data_i,
    input  logic [4:0]        reg_write_data_addr_i,
    input  logic [1:0]        mem_width_i,
    input  logic              mem_sign_extend_i,
    input  logic [1:0]        reg_src_i,
    input  logic              mem_write_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [3:0]        dmem_be_o,
    input  logic              dmem_ack_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_addr_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              misalign_o
);

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state;

    // Access attributes latched at request time; the load result is extracted
    // from these, not from the upstream fields.
    logic [1:0] a_q;
    logic [1:0] width_q;
    logic       sign_q;
    logic [4:0] rd_q;
    logic       we_q;

    logic [1:0]      a_lo;
    logic            mem_op;
    logic            misalign;
    logic            start;
    logic [3:0]      be_nxt;
    logic [XLEN-1:0] wdata_nxt;
    logic [XLEN-1:0] alu_wb;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_data;

    assign a_lo   = alu_result_i[1:0];
    assign mem_op = mem_write_i | (reg_src_i == 2'b01);
    assign start  = in_valid_i & mem_op & ~misalign;
    assign alu_wb = (reg_src_i == 2'b10) ? advance_pc_i : alu_result_i;

    always_comb begin
        case (mem_width_i)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = a_lo[0];
            2'b10:   misalign = |a_lo;
            default: misalign = 1'b1;
        endcase
    end

    // Stall covers the request cycle in IDLE and every BUSY cycle until ack,
    // so upstream advances on the same edge that retires the access.
    assign stall_o = (state == IDLE) ? start : ~dmem_ack_i;

    always_comb begin
        case (mem_width_i)
            2'b00: begin
                be_nxt    = 4'b0001 << a_lo;
                wdata_nxt = {4{reg_2_data_i[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << {a_lo[1], 1'b0};
                wdata_nxt = {2{reg_2_data_i[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = reg_2_data_i;
            end
        endcase
    end

    assign shifted = dmem_rdata_i >> {a_q, 3'b000};

    always_comb begin
        case (width_q)
            2'b00:   load_data = {{(XLEN-8){sign_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_data = {{(XLEN-16){sign_q & shifted[15]}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            a_q          <= '0;
            width_q      <= '0;
            sign_q       <= 1'b0;
            rd_q         <= '0;
            we_q         <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_wdata_o <= '0;
            dmem_be_o    <= '0;
            wb_valid_o   <= 1'b0;
            wb_addr_o    <= '0;
            wb_data_o    <= '0;
            misalign_o   <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            misalign_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        if (!mem_op) begin
                            wb_valid_o <= (reg_write_data_addr_i != 5'd0);
                            wb_addr_o  <= reg_write_data_addr_i;
                            wb_data_o  <= alu_wb;
                        end else if (misalign) begin
                            misalign_o <= 1'b1;
                        end else begin
                            state        <= BUSY;
                            a_q          <= a_lo;
                            width_q      <= mem_width_i;
                            sign_q       <= mem_sign_extend_i;
                            rd_q         <= reg_write_data_addr_i;
                            we_q         <= mem_write_i;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_write_i;
                            dmem_addr_o  <= {alu_result_i[ADDR_W-1:2], 2'b00};
                            dmem_be_o    <= be_nxt;
                            dmem_wdata_o <= wdata_nxt;
                        end
                    end
                end
                BUSY: begin
                    // dmem_* hold their values until the ack edge.
                    if (dmem_ack_i) begin
                        state      <= IDLE;
                        dmem_req_o <= 1'b0;
                        dmem_we_o  <= 1'b0;
                        if (!we_q) begin
                            wb_valid_o <= (rd_q != 5'd0);
                            wb_addr_o  <= rd_q;
                            wb_data_o  <= load_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic [31:0] advance_pc_i, alu_result_i, reg_2_data_i;
    logic [4:0]  reg_write_data_addr_i;
    logic [1:0]  mem_width_i;
    logic        mem_sign_extend_i;
    logic [1:0]  reg_src_i;
    logic        mem_write_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o;
    logic [4:0]  wb_addr_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    int checks = 0;
    int errors = 0;

    // values observed in the ack cycle of an access
    int          stalls;
    logic        cap_req, cap_we;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;

    mem_wb_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid_i),
        .advance_pc_i(advance_pc_i), .alu_result_i(alu_result_i),
        .reg_2_data_i(reg_2_data_i), .reg_write_data_addr_i(reg_write_data_addr_i),
        .mem_width_i(mem_width_i), .mem_sign_extend_i(mem_sign_extend_i),
        .reg_src_i(reg_src_i), .mem_write_i(mem_write_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o), .dmem_ack_i(dmem_ack_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o),
        .wb_data_o(wb_data_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic v, input logic [31:0] adv, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] rd, input logic [1:0] w,
                          input logic sx, input logic [1:0] src, input logic we);
        in_valid_i = v; advance_pc_i = adv; alu_result_i = alu; reg_2_data_i = rs2;
        reg_write_data_addr_i = rd; mem_width_i = w; mem_sign_extend_i = sx;
        reg_src_i = src; mem_write_i = we;
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Called #1 after an edge with an aligned memory op driven. Inserts `waits`
    // BUSY cycles without ack, then one ack cycle; returns #1 after the ack edge.
    task automatic mem_access(input int waits);
        stalls = 0;
        @(negedge clk); if (stall_o) stalls++;
        next_cycle();
        for (int w = 0; w < waits; w++) begin
            @(negedge clk); if (stall_o) stalls++;
            next_cycle();
        end
        dmem_ack_i = 1'b1;
        @(negedge clk);
        if (stall_o) stalls++;
        cap_req = dmem_req_o; cap_we = dmem_we_o; cap_addr = dmem_addr_o;
        cap_be = dmem_be_o; cap_wdata = dmem_wdata_o;
        next_cycle();
        dmem_ack_i = 1'b0;
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        #12;
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 0);
        chk("rst_misalign", {31'd0, misalign_o}, 0);
        chk("rst_req", {31'd0, dmem_req_o}, 0);
        chk("rst_stall", {31'd0, stall_o}, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_dmem_be", {28'd0, dmem_be_o}, 0);
        @(negedge clk); rst_n = 1'b1;
        next_cycle();

        // ALU op
        set_op(1, 32'h0, 32'h1234, 0, 5'd5, 2'b10, 0, 2'b00, 0);
        #1 chk("alu_stall", {31'd0, stall_o}, 0);
        next_cycle();
        chk("alu_wb_valid", {31'd0, wb_valid_o}, 1);
        chk("alu_wb_addr", {27'd0, wb_addr_o}, 5);
        chk("alu_wb_data", wb_data_o, 32'h1234);
        in_valid_i = 1'b0;
        next_cycle();
        chk("alu_pulse", {31'd0, wb_valid_o}, 0);

        // reg_src 11 behaves like ALU
        set_op(1, 32'h44, 32'h5678, 0, 5'd9, 2'b00, 0, 2'b11, 0);
        next_cycle();
        chk("src11_wb_data", wb_data_o, 32'h5678);
        in_valid_i = 1'b0;
        next_cycle();

        // signed byte load at 0x103, 3 wait cycles
        set_op(1, 0, 32'h103, 0, 5'd3, 2'b00, 1, 2'b01, 0);
        dmem_rdata_i = 32'h80FF_0000;
        #1 chk("lb_stall_idle", {31'd0, stall_o}, 1);
        mem_access(3);
        chk("lb_stall_cycles", stalls, 4);
        chk("lb_req", {31'd0, cap_req}, 1);
        chk("lb_we", {31'd0, cap_we}, 0);
        chk("lb_addr", cap_addr, 32'h100);
        chk("lb_be", {28'd0, cap_be}, 32'b1000);
        chk("lb_wb_valid", {31'd0, wb_valid_o}, 1);
        chk("lb_wb_addr", {27'd0, wb_addr_o}, 3);
        chk("lb_wb_data", wb_data_o, 32'hFFFF_FF80);
        chk("lb_req_done", {31'd0, dmem_req_o}, 0);
        next_cycle();
        chk("lb_pulse", {31'd0, wb_valid_o}, 0);

        // unsigned variant, immediate ack
        set_op(1, 0, 32'h103, 0, 5'd4, 2'b00, 0, 2'b01, 0);
        mem_access(0);
        chk("lbu_stall_cycles", stalls, 1);
        chk("lbu_wb_data", wb_data_o, 32'h0000_0080);
        next_cycle();

        // signed half load at 0x102 -> upper half 0x80FF
        set_op(1, 0, 32'h102, 0, 5'd6, 2'b01, 1, 2'b01, 0);
        mem_access(1);
        chk("lh_be", {28'd0, cap_be}, 32'b1100);
        chk("lh_wb_data", wb_data_o, 32'hFFFF_80FF);
        next_cycle();

        // half store at 0x202
        set_op(1, 0, 32'h202, 32'hAAAA_BEEF, 5'd7, 2'b01, 0, 2'b00, 1);
        mem_access(0);
        chk("sh_we", {31'd0, cap_we}, 1);
        chk("sh_addr", cap_addr, 32'h200);
        chk("sh_be", {28'd0, cap_be}, 32'b1100);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        chk("sh_wb_valid", {31'd0, wb_valid_o}, 0);
        next_cycle();

        // byte store at 0x301 replicates the byte
        set_op(1, 0, 32'h301, 32'h1234_56A5, 5'd0, 2'b00, 0, 2'b00, 1);
        mem_access(0);
        chk("sb_be", {28'd0, cap_be}, 32'b0010);
        chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        next_cycle();

        // misaligned word load
        set_op(1, 0, 32'h006, 0, 5'd8, 2'b10, 0, 2'b01, 0);
        #1 chk("mis_stall", {31'd0, stall_o}, 0);
        next_cycle();
        chk("mis_pulse", {31'd0, misalign_o}, 1);
        chk("mis_req", {31'd0, dmem_req_o}, 0);
        chk("mis_wb_valid", {31'd0, wb_valid_o}, 0);
        in_valid_i = 1'b0;
        next_cycle();
        chk("mis_pulse_end", {31'd0, misalign_o}, 0);

        // illegal width
        set_op(1, 0, 32'h010, 0, 5'd8, 2'b11, 0, 2'b01, 0);
        next_cycle();
        chk("illegal_width", {31'd0, misalign_o}, 1);
        in_valid_i = 1'b0;
        next_cycle();

        // JAL-style writeback
        set_op(1, 32'h44, 32'h999, 0, 5'd1, 2'b00, 0, 2'b10, 0);
        next_cycle();
        chk("jal_wb_valid", {31'd0, wb_valid_o}, 1);
        chk("jal_wb_data", wb_data_o, 32'h44);
        set_op(1, 32'h48, 32'h999, 0, 5'd0, 2'b00, 0, 2'b10, 0);
        next_cycle();
        chk("jal_rd0", {31'd0, wb_valid_o}, 0);
        in_valid_i = 1'b0;
        next_cycle();

        // reset while BUSY
        set_op(1, 0, 32'h010, 0, 5'd2, 2'b10, 0, 2'b01, 0);
        next_cycle();
        chk("rstbusy_req", {31'd0, dmem_req_o}, 1);
        rst_n = 1'b0;
        in_valid_i = 1'b0;
        #1 chk("rstbusy_req_drop", {31'd0, dmem_req_o}, 0);
        @(negedge clk); rst_n = 1'b1;
        dmem_ack_i = 1'b1;
        next_cycle();
        dmem_ack_i = 1'b0;
        chk("late_ack_wb", {31'd0, wb_valid_o}, 0);
        chk("late_ack_req", {31'd0, dmem_req_o}, 0);
        chk("late_ack_stall", {31'd0, stall_o}, 0);

        // state is IDLE: a fresh ALU op retires in one cycle
        set_op(1, 0, 32'hCAFE, 0, 5'd10, 2'b00, 0, 2'b00, 0);
        next_cycle();
        chk("post_rst_alu", wb_data_o, 32'hCAFE);
        in_valid_i = 1'b0;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
